// File: rtl/rv_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control path.
package rv_ctrl_pkg;

  // Major opcodes, instr[6:0]
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // pc_src select codes
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_JALR  = 2'd2;

  // trap_cause codes
  localparam logic [1:0] TC_NONE    = 2'd0;
  localparam logic [1:0] TC_ILLEGAL = 2'd1;
  localparam logic [1:0] TC_IMEM_TO = 2'd2;
  localparam logic [1:0] TC_DMEM_TO = 2'd3;

  // One-hot instruction class; all-zero means illegal / not yet decoded
  typedef struct packed {
    logic r;
    logic i;
    logic l;
    logic s;
    logic b;
    logic jal;
    logic jalr;
    logic lui;
    logic auipc;
  } op_class_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode -> one-hot class decode with illegal flag.
module opcode_classify
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls,
  output logic       illegal
);

  // Exactly one class bit for a legal opcode, none otherwise
  always_comb begin
    cls = '0;
    case (opcode)
      OP_R:     cls.r     = 1'b1;
      OP_I:     cls.i     = 1'b1;
      OP_L:     cls.l     = 1'b1;
      OP_S:     cls.s     = 1'b1;
      OP_B:     cls.b     = 1'b1;
      OP_JAL:   cls.jal   = 1'b1;
      OP_JALR:  cls.jalr  = 1'b1;
      OP_LUI:   cls.lui   = 1'b1;
      OP_AUIPC: cls.auipc = 1'b1;
      default:  ;
    endcase
    illegal = (cls == '0);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB with traps and
// a retired-instruction counter.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_write_en,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [2:0]  state,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret
);

  localparam logic            TO_EN  = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  op_class_t       cls_q, cls_d, dec_cls;
  logic            dec_illegal;
  logic [TO_W-1:0] to_q, to_d;
  logic [1:0]      cause_q, cause_d;
  logic [31:0]     instret_q, instret_d;
  logic            retire;
  logic            to_hit;

  opcode_classify u_classify (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign to_hit     = TO_EN && (to_q == TO_LIM);
  assign state      = state_q;
  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;
  assign instret    = instret_q;

  // Next state and strobes; everything is held low while rst_n is asserted so
  // an in-flight access is dropped the moment reset arrives.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    to_d         = '0;
    cause_d      = cause_q;
    retire       = 1'b0;
    imem_req     = 1'b0;
    ir_write     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_write_en = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_PLUS4;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_write = 1'b1;
            state_d  = S_DECODE;
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = TC_IMEM_TO;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        S_DECODE: begin
          cls_d = dec_cls;
          if (dec_illegal) begin
            state_d = S_TRAP;
            cause_d = TC_ILLEGAL;
          end else begin
            state_d = S_EXEC;
          end
        end
        S_EXEC: begin
          if (cls_q.l || cls_q.s) begin
            state_d = S_MEM;
          end else if (cls_q.b) begin
            retire   = 1'b1;
            pc_write = 1'b1;
            pc_src   = branch_taken ? PC_IMM : PC_PLUS4;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = cls_q.s;
          if (dmem_ready) begin
            if (cls_q.s) begin
              retire   = 1'b1;
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (to_hit) begin
            state_d = S_TRAP;
            cause_d = TC_DMEM_TO;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
        S_WB: begin
          retire       = 1'b1;
          reg_write_en = 1'b1;
          pc_write     = 1'b1;
          pc_src       = cls_q.jal ? PC_IMM : (cls_q.jalr ? PC_JALR : PC_PLUS4);
          state_d      = S_FETCH;
        end
        S_TRAP: ;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // Retire counter wraps naturally at 2^32
  always_comb instret_d = instret_q + 32'(retire);

  // State, class, timeout, cause and retire-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cls_q     <= '0;
      to_q      <= '0;
      cause_q   <= TC_NONE;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      to_q      <= to_d;
      cause_q   <= cause_d;
      instret_q <= instret_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: an instruction-level model emits the expected per-cycle
// outputs; a compare process checks the DUT against them every cycle.
module tb_multicycle_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic        branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic        imem_req, ir_write, dmem_req, dmem_we, reg_write_en, pc_write;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_write(ir_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_write_en(reg_write_en), .pc_write(pc_write), .pc_src(pc_src),
    .state(state), .trap(trap), .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        imem_req, ir_write, dmem_req, dmem_we, reg_write_en, pc_write;
    logic [1:0]  pc_src;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] instret;
  } obs_t;

  typedef enum int {K_R, K_I, K_L, K_S, K_B, K_JAL, K_JALR, K_LUI, K_AUIPC, K_ILL} kind_e;

  int          errors = 0, checks = 0, ncyc = 0;
  logic [31:0] m_instret = '0;
  logic [1:0]  m_cause = '0;
  bit          force_wrap = 0;
  obs_t        ex, nx;
  bit          exp_valid = 0;
  logic        d_rst = 1'b0, d_imem = 1'b0, d_dmem = 1'b0, d_bt = 1'b0;
  logic [6:0]  d_op = '0;

  function automatic kind_e kind_of(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_L;
      7'b0100011: return K_S;
      7'b1100011: return K_B;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.instret = m_instret;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got=%h want=%h", nm, got, want);
    end
  endtask

  // Apply staged inputs and expectation for one clock cycle
  task automatic cyc();
    @(negedge clk);
    rst_n = d_rst; imem_ready = d_imem; dmem_ready = d_dmem;
    branch_taken = d_bt; opcode = d_op;
    ex = nx; exp_valid = 1; ncyc++;
  endtask

  task automatic noise();
    d_imem = 1'($urandom); d_dmem = 1'($urandom);
    d_bt = 1'($urandom); d_op = 7'($urandom);
  endtask

  task automatic do_reset();
    m_instret = '0; m_cause = '0;
    for (int i = 0; i < 2; i++) begin
      noise(); d_rst = 1'b0; nx = mk(3'd0); cyc();
    end
    d_rst = 1'b1;
  endtask

  task automatic trap_cycles(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      noise(); nx = mk(3'd5); nx.trap = 1'b1; nx.cause = m_cause; cyc();
    end
  endtask

  // One instruction: fs fetch stalls, ms data stalls, branch outcome bt.
  task automatic run_instr(input logic [6:0] op, input int fs, input int ms, input logic bt,
                           input bit abort, output int n, output bit trapped);
    kind_e k;
    int c0;
    k = kind_of(op); c0 = ncyc; trapped = 0;
    for (int i = 0; i <= fs; i++) begin
      noise(); d_imem = (i == fs);
      nx = mk(3'd0); nx.imem_req = 1'b1; nx.ir_write = (i == fs);
      cyc();
      if (i < fs && i == TO - 1) begin
        m_cause = 2'd2; trapped = 1; n = ncyc - c0; return;
      end
    end
    if (force_wrap) begin
      #3; force dut.instret_q = 32'hFFFF_FFFF;
      #1; release dut.instret_q;
      m_instret = 32'hFFFF_FFFF; force_wrap = 0;
    end
    noise(); d_op = op; nx = mk(3'd1); cyc();
    if (k == K_ILL) begin
      m_cause = 2'd1; trapped = 1; n = ncyc - c0; return;
    end
    noise(); d_op = op; d_bt = bt; nx = mk(3'd2);
    if (k == K_B) begin nx.pc_write = 1'b1; nx.pc_src = bt ? 2'd1 : 2'd0; end
    cyc();
    if (k == K_B) begin m_instret++; n = ncyc - c0; return; end
    if (k == K_L || k == K_S) begin
      for (int i = 0; i <= ms; i++) begin
        if (abort && i == 1) begin do_reset(); n = ncyc - c0; return; end
        noise(); d_op = op; d_dmem = (i == ms);
        nx = mk(3'd3); nx.dmem_req = 1'b1; nx.dmem_we = (k == K_S);
        nx.pc_write = (i == ms && k == K_S);
        cyc();
        if (i < ms && i == TO - 1) begin
          m_cause = 2'd3; trapped = 1; n = ncyc - c0; return;
        end
      end
      if (k == K_S) begin m_instret++; n = ncyc - c0; return; end
    end
    noise(); d_op = op; nx = mk(3'd4);
    nx.reg_write_en = 1'b1; nx.pc_write = 1'b1;
    nx.pc_src = (k == K_JAL) ? 2'd1 : ((k == K_JALR) ? 2'd2 : 2'd0);
    cyc();
    m_instret++; n = ncyc - c0;
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      obs_t g;
      obs_t e;
      g = {state, imem_req, ir_write, dmem_req, dmem_we, reg_write_en, pc_write,
           pc_src, trap, trap_cause, instret};
      e = ex;
      if (!e.pc_write) begin g.pc_src = '0; e.pc_src = '0; end
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle %0d outputs: got st=%0d strobes=%b pc_src=%0d trap=%b cause=%0d instret=%h, want st=%0d strobes=%b pc_src=%0d trap=%b cause=%0d instret=%h",
                 ncyc, g.st, {g.imem_req, g.ir_write, g.dmem_req, g.dmem_we, g.reg_write_en, g.pc_write},
                 g.pc_src, g.trap, g.cause, g.instret,
                 e.st, {e.imem_req, e.ir_write, e.dmem_req, e.dmem_we, e.reg_write_en, e.pc_write},
                 e.pc_src, e.trap, e.cause, e.instret);
      end
    end
  end

  logic [6:0] legal [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

  initial begin
    int  n;
    bit  t;
    do_reset();
    #3; chk("reset_state", 32'(state), 0); chk("reset_instret", instret, 0);

    run_instr(7'b0110011, 0, 0, 1'b0, 0, n, t);
    chk("r_cycles", n, 4); chk("r_instret_model", m_instret, 1);

    run_instr(7'b0000011, 0, 3, 1'b0, 0, n, t);
    chk("load_cycles", n, 8); chk("load_instret_model", m_instret, 2);

    run_instr(7'b1100011, 0, 0, 1'b1, 0, n, t);
    chk("br_taken_cycles", n, 3);
    run_instr(7'b1100011, 0, 0, 1'b0, 0, n, t);
    chk("br_not_taken_cycles", n, 3);
    run_instr(7'b0100011, 0, 0, 1'b0, 0, n, t);
    chk("store_cycles", n, 4);

    run_instr(7'b0000000, 0, 0, 1'b0, 0, n, t);
    chk("illegal_trapped", 32'(t), 1); chk("illegal_cycles", n, 2);
    trap_cycles(20);
    #3; chk("illegal_cause", 32'(trap_cause), 1); chk("illegal_trap", 32'(trap), 1);
    do_reset();
    #3; chk("post_trap_state", 32'(state), 0); chk("post_trap_trap", 32'(trap), 0);

    run_instr(7'b0110011, 10, 0, 1'b0, 0, n, t);
    chk("imem_to_trapped", 32'(t), 1); chk("imem_to_cycles", n, 4);
    trap_cycles(3);
    #3; chk("imem_to_cause", 32'(trap_cause), 2);
    do_reset();
    run_instr(7'b0110011, 3, 0, 1'b0, 0, n, t);
    chk("imem_ready_at_limit", 32'(t), 0); chk("imem_late_cycles", n, 7);

    run_instr(7'b0000011, 0, 3, 1'b0, 0, n, t);
    chk("dmem_ready_at_limit", 32'(t), 0);
    run_instr(7'b0100011, 0, 9, 1'b0, 0, n, t);
    chk("dmem_to_trapped", 32'(t), 1);
    trap_cycles(2);
    #3; chk("dmem_to_cause", 32'(trap_cause), 3);
    do_reset();

    run_instr(7'b0100011, 0, 3, 1'b0, 1, n, t);

    run_instr(7'b1100111, 0, 0, 1'b0, 0, n, t);
    force_wrap = 1;
    run_instr(7'b1101111, 0, 0, 1'b0, 0, n, t);
    chk("wrap_model", m_instret, 0);
    run_instr(7'b0110111, 0, 0, 1'b0, 0, n, t);
    chk("after_wrap_model", m_instret, 1);

    for (int it = 0; it < 300; it++) begin
      logic [6:0] op;
      int fs, ms;
      op = ($urandom_range(0, 11) == 0) ? 7'($urandom) : legal[$urandom_range(0, 8)];
      fs = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      ms = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 3);
      run_instr(op, fs, ms, 1'($urandom), ($urandom_range(0, 49) == 0), n, t);
      if (t) begin
        trap_cycles($urandom_range(1, 4));
        do_reset();
      end
    end

    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Control FSM for the multi-cycle variant of the RV32I core.
- Sequences each instruction through five steps: instruction fetch, decode/register-file read, ALU execute, data-memory access and register write-back.
- Drives the IR/PC write strobes, memory requests with ready handshakes, register-file write enable and PC-source select.
- Traps on illegal opcodes and memory timeouts, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255: max consecutive not-ready cycles tolerated on imem/dmem before trapping; 0 disables the timeout.
- TO_W, 8: width of the timeout counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  instr[6:0] from the IR; stable from the cycle after ir_write
- branch_taken  in  1  ALU branch-compare result, valid in EXEC
- imem_ready  in  1  instruction memory has valid data this cycle
- dmem_ready  in  1  data memory has completed the access this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch instruction into IR
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- reg_write_en  out  1  register-file write strobe
- pc_write  out  1  update PC this cycle
- pc_src  out  2  0=pc+4, 1=pc+imm (branch/jal), 2=(rs1+imm)&~1 (jalr)
- state  out  3  current state encoding
- trap  out  1  core halted
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout
- instret  out  32  retired-instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (asynchronous, rst_n=0): state=FETCH, instret=0, trap=0, trap_cause=0, timeout count=0, latched class=0.
- Outputs are combinational from state, latched class and ready inputs. All strobes drop in the same cycle rst_n falls, including mid-access.
- Opcode classes, latched in DECODE:
  - R=0110011, I=0010011, L=0000011, S=0100011, B=1100011
  - JAL=1101111, JALR=1100111, LUI=0110111, AUIPC=0010111
  - Any other opcode is ILLEGAL.
- FETCH:
  - imem_req=1.
  - If imem_ready: ir_write=1 and go to DECODE.
  - Else stay and increment the timeout count.
- DECODE: one cycle.
  - Latch the opcode class.
  - ILLEGAL: go to TRAP with cause 1.
  - Otherwise go to EXEC.
- EXEC: one cycle.
  - L or S: go to MEM.
  - B: retire. pc_write=1, pc_src=branch_taken?1:0, go to FETCH.
  - All other classes: go to WB.
- MEM:
  - dmem_req=1; dmem_we=1 for S only.
  - On dmem_ready, L goes to WB.
  - On dmem_ready, S retires: pc_write=1, pc_src=0, go to FETCH.
  - Without dmem_ready: stay and increment the timeout count.
- WB: retire.
  - reg_write_en=1 and pc_write=1.
  - pc_src=1 for JAL, 2 for JALR, 0 for all other classes.
  - Go to FETCH.
- Retire: instret increments by 1 on each retire cycle and wraps 0xFFFFFFFF to 0.
- TRAP:
  - Terminal until reset.
  - trap=1 and trap_cause holds.
  - All strobes are 0 and instret is frozen.
- Timeout:
  - The count clears on every state change and whenever ready is seen.
  - When MEM_TIMEOUT≠0, ready is low and count==MEM_TIMEOUT-1, go to TRAP with cause 2 (FETCH) or 3 (MEM).
  - If ready arrives in the same cycle the limit is reached, ready wins and no trap occurs.
- Latency: minimum 3 cycles for B, 4 for R/I/LUI/AUIPC/JAL/JALR/S, 5 for L; add one cycle per not-ready cycle.

Decomposition:
- Shared package (rv_ctrl_pkg) holds:
  - the opcode constants (OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - the state encodings;
  - the pc_src and trap_cause codes.
- One natural sub-module, opcode_classify: combinational opcode to one-hot class plus illegal flag. It is reusable by the future pipelined hazard unit.

Test Plan:
- R-type (0110011), imem_ready always 1 -> states 0,1,2,4,0; reg_write_en and pc_write high only in WB with pc_src=0; instret=1.
- Load (0000011), dmem_ready low 3 cycles -> MEM held 4 cycles, dmem_we=0; WB follows; instret increments once; total 8 cycles.
- Branch with branch_taken=1, then again with 0 -> retire in EXEC with pc_src=1 then 0; 3 cycles each; reg_write_en never high.
- Opcode 0000000 -> DECODE to TRAP; trap=1, cause=1; no strobes for 20 further cycles; rst_n low returns state=0 and trap=0.
- MEM_TIMEOUT=4 with imem_ready stuck low -> trap cause 2 after exactly 4 FETCH cycles. Repeat with ready on the 4th cycle -> DECODE, no trap.
- JALR then JAL -> WB pc_src=2 then 1; preload instret to 0xFFFFFFFF via back-to-back retires (force) and check wrap to 0.
